// File: rtl/cache_plru_victim_if.sv
// Request/response bundle for the PLRU victim selector.
interface cache_plru_victim_if #(
  parameter int SET_W    = 4,
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3
);
  logic                req_valid;
  logic                req_ready;
  logic                req_alloc;
  logic [SET_W-1:0]    req_set;
  logic [WAYS_REP-1:0] req_way;
  logic [WAYS-1:0]     req_vmask;
  logic                rsp_valid;
  logic [WAYS_REP-1:0] rsp_way;
  logic                rsp_ready;

  modport master (
    output req_valid, req_alloc, req_set, req_way, req_vmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_way
  );

  modport slave (
    input  req_valid, req_alloc, req_set, req_way, req_vmask, rsp_ready,
    output req_ready, rsp_valid, rsp_way
  );
endinterface

// File: rtl/cache_plru_victim.sv
// Tree-PLRU state keeper and victim selector for an 8-way cache.
// Each set holds a 7-bit tree: bit 0 is the root, bits 1/2 the
// half-level nodes, bits 3..6 the leaf-pair nodes. A flush sweeps the
// trees back to zero one set per cycle.
module cache_plru_victim #(
  parameter int SETS     = 16,
  parameter int SET_W    = 4,
  parameter int WAYS     = 8,
  parameter int WAYS_REP = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                busy,
  cache_plru_victim_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [SET_W-1:0] SWEEP_LAST = SET_W'(SETS - 1);

  // Point the three path bits toward the accessed way.
  function automatic logic [6:0] plru_update(input logic [6:0] t,
                                             input logic [WAYS_REP-1:0] w);
    logic [6:0] n;
    n = t;
    case (w)
      3'd0: begin n[0] = 1'b0; n[1] = 1'b0; n[3] = 1'b0; end
      3'd1: begin n[0] = 1'b0; n[1] = 1'b0; n[3] = 1'b1; end
      3'd2: begin n[0] = 1'b0; n[1] = 1'b1; n[4] = 1'b0; end
      3'd3: begin n[0] = 1'b0; n[1] = 1'b1; n[4] = 1'b1; end
      3'd4: begin n[0] = 1'b1; n[2] = 1'b0; n[5] = 1'b0; end
      3'd5: begin n[0] = 1'b1; n[2] = 1'b0; n[5] = 1'b1; end
      3'd6: begin n[0] = 1'b1; n[2] = 1'b1; n[6] = 1'b0; end
      3'd7: begin n[0] = 1'b1; n[2] = 1'b1; n[6] = 1'b1; end
      default: n = t;
    endcase
    return n;
  endfunction

  // Follow the tree away from the most recently used side at each level.
  function automatic logic [WAYS_REP-1:0] plru_victim(input logic [6:0] t);
    logic [WAYS_REP-1:0] v;
    v[2] = ~t[0];
    if (!v[2]) begin
      v[1] = ~t[1];
      v[0] = v[1] ? ~t[4] : ~t[3];
    end else begin
      v[1] = ~t[2];
      v[0] = v[1] ? ~t[6] : ~t[5];
    end
    return v;
  endfunction

  // Lowest-index way whose valid bit is clear (0 if none; caller gates use).
  function automatic logic [WAYS_REP-1:0] first_invalid(input logic [WAYS-1:0] vm);
    logic [WAYS_REP-1:0] w;
    w = {WAYS_REP{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vm[i]) begin
        w = WAYS_REP'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  state_e              state_q, state_d;
  logic [SET_W-1:0]    sweep_q;
  logic [6:0]          tree_q [SETS];
  logic                rsp_valid_q;
  logic [WAYS_REP-1:0] rsp_way_q;

  logic                busy_s;
  logic                clear_en_s;
  logic                req_ready_s;
  logic                accept_s;
  logic [6:0]          rd_tree_s;
  logic [WAYS_REP-1:0] victim_s;
  logic [WAYS_REP-1:0] upd_way_s;
  logic [6:0]          wr_tree_s;

  // Request datapath: read the set tree, pick a victim and form the updated tree.
  always_comb begin
    req_ready_s = !busy_s && !flush && (!rsp_valid_q || bus.rsp_ready);
    accept_s    = bus.req_valid && req_ready_s;
    rd_tree_s   = tree_q[bus.req_set];
    if (&bus.req_vmask) begin
      victim_s = plru_victim(rd_tree_s);
    end else begin
      victim_s = first_invalid(bus.req_vmask);
    end
    if (bus.req_alloc) begin
      upd_way_s = victim_s;
    end else begin
      upd_way_s = bus.req_way;
    end
    wr_tree_s = plru_update(rd_tree_s, upd_way_s);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush always (re)starts the sweep; the sweep ends on the last set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (sweep_q == SWEEP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy while sweeping; a restarting flush suppresses this cycle's clear.
  always_comb begin
    busy_s     = 1'b0;
    clear_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s     = 1'b0;
        clear_en_s = 1'b0;
      end
      ST_FLUSH: begin
        busy_s     = 1'b1;
        clear_en_s = !flush;
      end
      default: begin
        busy_s     = 1'b0;
        clear_en_s = 1'b0;
      end
    endcase
  end

  // Sweep counter: restart on flush, advance per cleared set, wraps naturally at SETS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_q <= {SET_W{1'b0}};
    end else if (flush) begin
      sweep_q <= {SET_W{1'b0}};
    end else if (clear_en_s) begin
      sweep_q <= sweep_q + {{(SET_W-1){1'b0}}, 1'b1};
    end else begin
      sweep_q <= sweep_q;
    end
  end

  // Tree storage: sweep clears and request updates never coincide (busy blocks requests).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        tree_q[i] <= 7'b0000000;
      end
    end else if (clear_en_s) begin
      tree_q[sweep_q] <= 7'b0000000;
    end else if (accept_s) begin
      tree_q[bus.req_set] <= wr_tree_s;
    end
  end

  // Response register: load on accepted allocate, hold until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= {WAYS_REP{1'b0}};
    end else if (accept_s && bus.req_alloc) begin
      rsp_valid_q <= 1'b1;
      rsp_way_q   <= victim_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= rsp_way_q;
    end else begin
      rsp_valid_q <= rsp_valid_q;
      rsp_way_q   <= rsp_way_q;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_way   = rsp_way_q;
  assign busy          = busy_s;

endmodule

// File: tb/tb_cache_plru_victim.sv
// Scoreboarded bench for cache_plru_victim with a heap-walk PLRU model.
module tb_cache_plru_victim;

  typedef struct {
    int way;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];
  int   seen_q[$];
  bit   mtree [16][8];

  cache_plru_victim_if #(.SET_W(4), .WAYS(8), .WAYS_REP(3)) bus ();

  cache_plru_victim #(.SETS(16), .SET_W(4), .WAYS(8), .WAYS_REP(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tree as a heap (node 1 root, children 2n/2n+1); bit=1 means right half used.
  function automatic void m_clear();
    for (int s = 0; s < 16; s++)
      for (int n = 0; n < 8; n++)
        mtree[s][n] = 1'b0;
  endfunction

  function automatic void m_update(input int s, input int w);
    int node = 1;
    for (int l = 2; l >= 0; l--) begin
      int d = (w >> l) & 1;
      mtree[s][node] = d[0];
      node = node * 2 + d;
    end
  endfunction

  function automatic int m_victim(input int s);
    int node = 1;
    int w = 0;
    for (int l = 0; l < 3; l++) begin
      int d = mtree[s][node] ? 0 : 1;
      w = w * 2 + d;
      node = node * 2 + d;
    end
    return w;
  endfunction

  function automatic void model_accept(input bit alloc, input int s, input int w,
                                       input logic [7:0] vm);
    int v;
    exp_t e;
    if (alloc) begin
      if (vm != 8'hFF) begin
        v = 0;
        while (vm[v]) v++;
      end else begin
        v = m_victim(s);
      end
      m_update(s, v);
      e.way = v;
      e.due = cyc + 1;
      exp_q.push_back(e);
    end else begin
      m_update(s, w);
    end
  endfunction

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          chk("rsp_way", int'(bus.rsp_way), exp_q[0].way);
          if (bus.rsp_ready) begin
            seen_q.push_back(int'(bus.rsp_way));
            void'(exp_q.pop_front());
          end
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        chk("rsp_late", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic issue(input bit alloc, input int s, input int w, input logic [7:0] vm);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_alloc = alloc;
    bus.req_set   = 4'(s);
    bus.req_way   = 3'(w);
    bus.req_vmask = vm;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_timeout", 0, 1);
    else model_accept(alloc, s, w, vm);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic alloc_expect(input string name, input int s, input logic [7:0] vm,
                              input int exp_way);
    seen_q.delete();
    issue(1'b1, s, 0, vm);
    wait_drain();
    chk(name, (seen_q.size() > 0) ? seen_q[0] : -1, exp_way);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_ready", int'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_and_count(output int bc);
    int n = 0;
    bit done = 1'b0;
    bc = 0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    m_clear();
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) begin
        bc++;
        chk("busy_ready", int'(bus.req_ready), 0);
      end else begin
        done = 1'b1;
      end
    end
    chk("post_flush_ready", int'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bus.req_valid = 1'b0;
    bus.req_alloc = 1'b0;
    bus.req_set   = 4'd0;
    bus.req_way   = 3'd0;
    bus.req_vmask = 8'hFF;
    bus.rsp_ready = 1'b1;
    m_clear();
    do_reset();

    // First allocate on a clean set then a back-to-back one to the same set.
    seen_q.delete();
    issue(1'b1, 0, 0, 8'hFF);
    issue(1'b1, 0, 0, 8'hFF);
    wait_drain();
    chk("b2b_count", seen_q.size(), 2);
    chk("alloc_first", (seen_q.size() > 0) ? seen_q[0] : -1, 7);
    chk("alloc_b2b", (seen_q.size() > 1) ? seen_q[1] : -1, 3);

    // Invalid-way preference, then the tree it left behind.
    alloc_expect("inval_way2", 2, 8'hFB, 2);
    alloc_expect("after_way2", 2, 8'hFF, 7);
    alloc_expect("inval_all", 7, 8'h00, 0);
    alloc_expect("inval_top", 8, 8'h7F, 7);
    alloc_expect("inval_way6", 9, 8'hBF, 6);

    // Touch then allocate.
    issue(1'b0, 3, 5, 8'h00);
    alloc_expect("touch_alloc", 3, 8'hFF, 3);

    // Backpressure: response held, new request stalled for 4 cycles.
    bus.rsp_ready = 1'b0;
    seen_q.delete();
    issue(1'b1, 5, 0, 8'hFF);
    bus.req_valid = 1'b1;
    bus.req_alloc = 1'b1;
    bus.req_set   = 4'd6;
    bus.req_vmask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_req_ready", int'(bus.req_ready), 0);
      chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", int'(bus.req_ready), 1);
    if (bus.req_ready) model_accept(1'b1, 6, 0, 8'hFF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_drain();
    chk("bp_count", seen_q.size(), 2);

    // Flush after dirtying sets 0 and 15.
    issue(1'b0, 0, 3, 8'h00);
    issue(1'b0, 15, 6, 8'h00);
    pulse_and_count(bc);
    chk("busy_cycles", bc, 16);
    alloc_expect("flush_set15", 15, 8'hFF, 7);
    alloc_expect("flush_set0", 0, 8'hFF, 7);

    // Flush restarted mid-sweep.
    issue(1'b0, 1, 7, 8'h00);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse_and_count(bc);
    chk("restart_busy_cycles", bc, 16);
    alloc_expect("restart_set1", 1, 8'hFF, 7);

    // Pending response survives flush, then reset discards it.
    bus.rsp_ready = 1'b0;
    issue(1'b1, 4, 0, 8'hFF);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_keeps_rsp", int'(bus.rsp_valid), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_flush_busy", int'(busy), 1);
      chk("mid_flush_rsp", int'(bus.rsp_valid), 1);
    end
    do_reset();
    bus.rsp_ready = 1'b1;
    alloc_expect("post_reset_set4", 4, 8'hFF, 7);

    // Randomized traffic with random response backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit a;
      int s;
      int w;
      logic [7:0] vm;
      a  = ($urandom_range(0, 1) == 1);
      s  = $urandom_range(0, 15);
      w  = $urandom_range(0, 7);
      vm = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom_range(0, 255));
      issue(a, s, w, vm);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_drain();
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_plru_victim.md
CACHE_PLRU_VICTIM -- requirements
Module: cache_plru_victim

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- SETS, 16, number of sets tracked.
- SET_W, 4, set index width, equal to log2(SETS).
- WAYS, 8, associativity; only 8 is supported.
- WAYS_REP, 3, encoded way width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- flush, in, 1, one-cycle pulse that starts clearing all PLRU state.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when req_valid && req_ready.
- req_alloc, in, 1, 1 = allocate (victim select), 0 = touch (hit update).
- req_set, in, SET_W, set index.
- req_way, in, WAYS_REP, accessed way; used for touch only.
- req_vmask, in, WAYS, per-way valid bits of the set; used for allocate only.
- rsp_valid, out, 1, victim response present.
- rsp_way, out, WAYS_REP, victim way.
- rsp_ready, in, 1, response consumed when rsp_valid && rsp_ready.
- busy, out, 1, flush sweep in progress.

Function
REQ-003 The block SHALL hold one 7-bit PLRU tree per set in flops, with bits b0..b6 arranged as follows:
- b0 = 1 when the last access was to ways 4-7.
- b1 = 1 for ways 2-3 within ways 0-3.
- b2 = 1 for ways 6-7 within ways 4-7.
- b3 = 1 for way 1 over way 0.
- b4 = 1 for way 3 over way 2.
- b5 = 1 for way 5 over way 4.
- b6 = 1 for way 7 over way 6.
REQ-004 The update for way w SHALL set the three path bits to point toward w and leave the other four bits unchanged, with these values:
- way 0: b0=0, b1=0, b3=0.
- way 1: b0=0, b1=0, b3=1.
- way 2: b0=0, b1=1, b4=0.
- way 3: b0=0, b1=1, b4=1.
- way 4: b0=1, b2=0, b5=0.
- way 5: b0=1, b2=0, b5=1.
- way 6: b0=1, b2=1, b6=0.
- way 7: b0=1, b2=1, b6=1.
REQ-005 The PLRU victim SHALL be computed as follows:
- v[2] = ~b0.
- If v[2]=0: v[1] = ~b1, and v[0] = v[1] ? ~b4 : ~b3.
- If v[2]=1: v[1] = ~b2, and v[0] = v[1] ? ~b6 : ~b5.
REQ-006 On an allocate, if req_vmask is not all ones, the victim SHALL be the lowest-index way whose req_vmask bit is 0; otherwise it SHALL be the PLRU victim.
REQ-007 An accepted allocate SHALL perform the following:
- Read the set tree in the accept cycle.
- Write update(victim) to the set at the next edge.
- Assert rsp_valid with rsp_way = victim on the following cycle, giving 1-cycle latency.
REQ-008 An accepted touch SHALL write update(req_way) to req_set at the next edge and SHALL produce no response.
REQ-009 req_ready SHALL equal !busy && !flush && (!rsp_valid || rsp_ready).
REQ-010 rsp_valid and rsp_way SHALL hold stable until rsp_ready is seen.
REQ-011 Back-to-back requests to the same set SHALL observe the previous request's update, with no stale read.
REQ-012 The control FSM SHALL have states IDLE and FLUSH, with these transitions and actions:
- flush in IDLE: go to FLUSH, set busy=1, and clear the sweep counter to 0.
- In FLUSH: clear one set per cycle, in index order 0..SETS-1.
- After set SETS-1 is cleared: return to IDLE, so busy is high for exactly SETS cycles.
REQ-013 flush asserted while in FLUSH SHALL restart the sweep at set 0.
REQ-014 flush and an accepted request SHALL be mutually exclusive, since req_ready is 0 whenever flush=1; a pending rsp_valid SHALL be unaffected by flush.
REQ-015 The sweep counter SHALL be SET_W bits wide and SHALL wrap cleanly, with no out-of-range write.

Reset
REQ-016 When rst_n=0 at a clk edge, the block SHALL do all of the following in that cycle:
- Clear all trees to 7'b0000000.
- Set the FSM to IDLE and the sweep counter to 0.
- Set rsp_valid=0, rsp_way=0 and busy=0.
REQ-017 A reset during FLUSH or with a response pending SHALL abort the operation and discard the response.
REQ-018 After reset is released, req_ready SHALL be 1 on the first cycle.

Verification
REQ-019 Reset, then allocate set 0 with vmask=0xFF -> rsp_way=7 one cycle later; set-0 tree becomes 7'b1000101.
REQ-020 A second allocate to set 0 with vmask=0xFF, issued back-to-back -> rsp_way=3, which checks REQ-011.
REQ-021 Allocate set 2 with vmask=0xFB -> rsp_way=2 (invalid way preferred); set-2 tree becomes b0=0, b1=1, b4=0.
REQ-022 Touch set 3 way 5, then allocate set 3 with vmask=0xFF -> rsp_way=3.
REQ-023 Backpressure: hold rsp_ready=0 for 4 cycles with req_valid=1 -> rsp_way stable, req_ready=0 throughout; one request is accepted after rsp_ready=1.
REQ-024 Dirty sets 0 and 15, pulse flush -> busy=1 for 16 cycles with req_ready=0; afterwards, allocate set 15 -> rsp_way=7.
